mc_cu: RTL and testbench

MC_CU -- requirements
Module: mc_cu

---
 rtl/mc_cu.sv | 232 +++++++++++++++++++++++
 tb/tb_mc_cu.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_cu.sv
// rtl/mc_cu.sv - multi-cycle RV32I control unit (fetch/decode/execute/mem/wb/trap)
module mc_cu #(
   parameter int TIMEOUT = 16,
   parameter bit TRAP_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       mem_ready,
   input  logic       branch_taken,
   output logic [2:0] state,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       mem_req,
   output logic       mem_is_fetch,
   output logic [2:0] mem_read,
   output logic [1:0] mem_write,
   output logic [1:0] mem_out_sel,
   output logic [1:0] alu_op,
   output logic       alu_src,
   output logic       reg_write,
   output logic       illegal_instr,
   output logic       bus_err,
   output logic       instr_retired
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] wait_cnt;
   logic       cause_ill_q, cause_ill_d, cause_bus_q, cause_bus_d;

   logic       legal, is_load, is_store, is_branch, timeout, exe_ctl;
   logic [2:0] load_rd;
   logic [1:0] store_wr, alu_op_dec, osel_dec;
   logic       alu_src_dec;

   logic       ir_write_c, pc_write_c, mem_req_c, mem_is_fetch_c, reg_write_c;
   logic       ill_c, berr_c;
   logic [1:0] pc_src_c, mem_write_c;
   logic [2:0] mem_read_c;

   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign timeout   = TRAP_EN && !mem_ready && (wait_cnt == TIMEOUT_C);

   always_comb begin
      legal       = 1'b0;
      alu_op_dec  = 2'b00;
      alu_src_dec = 1'b1;
      osel_dec    = 2'b01;
      case (opcode)
         OP_LUI:    legal = 1'b1;
         OP_AUIPC:  begin legal = 1'b1; alu_op_dec = 2'b10; osel_dec = 2'b10; end
         OP_JAL:    begin legal = 1'b1; osel_dec = 2'b11; end
         OP_JALR:   begin legal = (funct3 == 3'b000); alu_op_dec = 2'b10; osel_dec = 2'b11; end
         OP_OPIMM:  begin legal = 1'b1; alu_op_dec = 2'b11; end
         OP_OP:     begin legal = 1'b1; alu_op_dec = 2'b11; alu_src_dec = 1'b0; end
         OP_LOAD:   begin
            legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            alu_op_dec = 2'b10;
            osel_dec   = 2'b00;
         end
         OP_STORE:  begin legal = funct3 inside {3'b000, 3'b001, 3'b010}; alu_op_dec = 2'b10; end
         OP_BRANCH: begin
            legal = !(funct3 inside {3'b010, 3'b011});
            alu_op_dec  = 2'b01;
            alu_src_dec = 1'b0;
         end
         default:   legal = 1'b0;
      endcase
   end

   always_comb begin
      case (funct3)
         3'b000:  load_rd = 3'b100;
         3'b001:  load_rd = 3'b010;
         3'b010:  load_rd = 3'b001;
         3'b100:  load_rd = 3'b101;
         3'b101:  load_rd = 3'b011;
         default: load_rd = 3'b000;
      endcase
      case (funct3)
         3'b000:  store_wr = 2'b11;
         3'b001:  store_wr = 2'b10;
         3'b010:  store_wr = 2'b01;
         default: store_wr = 2'b00;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      cause_ill_d    = 1'b0;
      cause_bus_d    = 1'b0;
      ir_write_c     = 1'b0;
      pc_write_c     = 1'b0;
      pc_src_c       = 2'b00;
      mem_req_c      = 1'b0;
      mem_is_fetch_c = 1'b0;
      mem_read_c     = 3'b000;
      mem_write_c    = 2'b00;
      reg_write_c    = 1'b0;
      ill_c          = 1'b0;
      berr_c         = 1'b0;
      exe_ctl        = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req_c      = 1'b1;
            mem_is_fetch_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               state_d    = S_DECODE;
            end else if (timeout) begin
               state_d     = S_TRAP;
               cause_bus_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXECUTE;
            end else if (TRAP_EN) begin
               state_d     = S_TRAP;
               cause_ill_d = 1'b1;
            end else begin
               pc_write_c = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_EXECUTE: begin
            exe_ctl = 1'b1;
            if (is_branch) begin
               pc_write_c = 1'b1;
               pc_src_c   = branch_taken ? 2'b01 : 2'b00;
               state_d    = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            exe_ctl     = 1'b1;
            mem_req_c   = 1'b1;
            mem_read_c  = is_load  ? load_rd  : 3'b000;
            mem_write_c = is_store ? store_wr : 2'b00;
            if (mem_ready) begin
               if (is_store) begin
                  pc_write_c = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout) begin
               state_d     = S_TRAP;
               cause_bus_d = 1'b1;
            end
         end
         S_WB: begin
            exe_ctl     = 1'b1;
            reg_write_c = 1'b1;
            pc_write_c  = 1'b1;
            pc_src_c    = (opcode == OP_JAL) ? 2'b01 : (opcode == OP_JALR) ? 2'b10 : 2'b00;
            state_d     = S_FETCH;
         end
         S_TRAP: begin
            pc_write_c = 1'b1;
            pc_src_c   = 2'b11;
            ill_c      = cause_ill_q;
            berr_c     = cause_bus_q;
            state_d    = S_FETCH;
         end
         default: state_d = S_TRAP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_FETCH;
         wait_cnt    <= 8'd0;
         cause_ill_q <= 1'b0;
         cause_bus_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cause_ill_q <= cause_ill_d;
         cause_bus_q <= cause_bus_d;
         // Counter restarts each time a new handshake phase begins.
         if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q)
            wait_cnt <= 8'd0;
         else if (mem_req_c && !mem_ready && wait_cnt != 8'hff)
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   // Every output is forced low while reset is held, whatever the registered state.
   assign state         = rst_n ? state_q : 3'd0;
   assign ir_write      = rst_n & ir_write_c;
   assign pc_write      = rst_n & pc_write_c;
   assign pc_src        = rst_n ? pc_src_c : 2'b00;
   assign mem_req       = rst_n & mem_req_c;
   assign mem_is_fetch  = rst_n & mem_is_fetch_c;
   assign mem_read      = rst_n ? mem_read_c : 3'b000;
   assign mem_write     = rst_n ? mem_write_c : 2'b00;
   assign mem_out_sel   = (rst_n && exe_ctl) ? osel_dec : 2'b00;
   assign alu_op        = (rst_n && exe_ctl) ? alu_op_dec : 2'b00;
   assign alu_src       = rst_n & exe_ctl & alu_src_dec;
   assign reg_write     = rst_n & reg_write_c;
   assign illegal_instr = rst_n & ill_c;
   assign bus_err       = rst_n & berr_c;
   assign instr_retired = rst_n & pc_write_c & (state_q != S_TRAP);

endmodule

// File: tb/tb_mc_cu.sv
// tb/tb_mc_cu.sv - scoreboard testbench for mc_cu (TIMEOUT=4, TRAP_EN=1)
module tb_mc_cu;

   typedef struct packed {
      logic [2:0] st;
      logic       ir_w;
      logic       pc_w;
      logic [1:0] pc_src;
      logic       mreq;
      logic       mfetch;
      logic [2:0] mrd;
      logic [1:0] mwr;
      logic [1:0] osel;
      logic [1:0] aop;
      logic       asrc;
      logic       rw;
      logic       ill;
      logic       berr;
      logic       ret;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       mem_ready, branch_taken;
   logic [2:0] state, mem_read;
   logic       ir_write, pc_write, mem_req, mem_is_fetch, alu_src, reg_write;
   logic       illegal_instr, bus_err, instr_retired;
   logic [1:0] pc_src, mem_write, mem_out_sel, alu_op;

   exp_t  act;
   exp_t  exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   mc_cu #(.TIMEOUT(4), .TRAP_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
      .mem_ready(mem_ready), .branch_taken(branch_taken), .state(state),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .mem_req(mem_req), .mem_is_fetch(mem_is_fetch), .mem_read(mem_read),
      .mem_write(mem_write), .mem_out_sel(mem_out_sel), .alu_op(alu_op),
      .alu_src(alu_src), .reg_write(reg_write), .illegal_instr(illegal_instr),
      .bus_err(bus_err), .instr_retired(instr_retired)
   );

   assign act = {state, ir_write, pc_write, pc_src, mem_req, mem_is_fetch, mem_read,
                 mem_write, mem_out_sel, alu_op, alu_src, reg_write, illegal_instr,
                 bus_err, instr_retired};

   // Monitor: one expected record per observed cycle, checked mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         n_checks++;
         if (act !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", t, act, e);
         end
      end
   end

   function automatic exp_t f_fetch(input logic rdy);
      exp_t e = '0;
      e.mreq = 1'b1; e.mfetch = 1'b1; e.ir_w = rdy;
      return e;
   endfunction

   function automatic exp_t f_dec();
      exp_t e = '0;
      e.st = 3'd1;
      return e;
   endfunction

   function automatic exp_t f_exe(input logic [1:0] aop, input logic asrc, input logic [1:0] osel,
                                  input logic pcw, input logic [1:0] pcs);
      exp_t e = '0;
      e.st = 3'd2; e.aop = aop; e.asrc = asrc; e.osel = osel;
      e.pc_w = pcw; e.pc_src = pcs; e.ret = pcw;
      return e;
   endfunction

   function automatic exp_t f_mem(input logic [2:0] rd, input logic [1:0] wr, input logic [1:0] aop,
                                  input logic asrc, input logic [1:0] osel, input logic pcw);
      exp_t e = '0;
      e.st = 3'd3; e.mreq = 1'b1; e.mrd = rd; e.mwr = wr;
      e.aop = aop; e.asrc = asrc; e.osel = osel; e.pc_w = pcw; e.ret = pcw;
      return e;
   endfunction

   function automatic exp_t f_wb(input logic [1:0] aop, input logic asrc, input logic [1:0] osel,
                                 input logic [1:0] pcs);
      exp_t e = '0;
      e.st = 3'd4; e.aop = aop; e.asrc = asrc; e.osel = osel;
      e.rw = 1'b1; e.pc_w = 1'b1; e.pc_src = pcs; e.ret = 1'b1;
      return e;
   endfunction

   function automatic exp_t f_trap(input logic ill, input logic berr);
      exp_t e = '0;
      e.st = 3'd5; e.pc_w = 1'b1; e.pc_src = 2'b11; e.ill = ill; e.berr = berr;
      return e;
   endfunction

   task automatic cyc(input logic rdy, input logic bt, input exp_t e, input string t);
      mem_ready    = rdy;
      branch_taken = bt;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] f3);
      opcode = op;
      funct3 = f3;
   endtask

   initial begin
      rst_n = 1'b0; mem_ready = 1'b0; branch_taken = 1'b0;
      opcode = 7'd0; funct3 = 3'd0;
      @(posedge clk);
      #1;
      cyc(0, 0, '0, "reset_idle");
      cyc(1, 0, '0, "reset_ready_gated");
      rst_n = 1'b1;

      instr(7'b0110011, 3'b000);
      cyc(1, 0, f_fetch(1), "add_fetch");
      cyc(0, 0, f_dec(), "add_decode");
      cyc(0, 0, f_exe(2'b11, 0, 2'b01, 0, 2'b00), "add_execute");
      cyc(0, 0, f_wb(2'b11, 0, 2'b01, 2'b00), "add_wb");

      instr(7'b0000011, 3'b010);
      cyc(1, 0, f_fetch(1), "lw_fetch");
      cyc(0, 0, f_dec(), "lw_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b00, 0, 2'b00), "lw_execute");
      for (int i = 0; i < 3; i++) cyc(0, 0, f_mem(3'b001, 2'b00, 2'b10, 1, 2'b00, 0), "lw_mem_wait");
      cyc(1, 0, f_mem(3'b001, 2'b00, 2'b10, 1, 2'b00, 0), "lw_mem_done");
      cyc(0, 0, f_wb(2'b10, 1, 2'b00, 2'b00), "lw_wb");

      instr(7'b1100011, 3'b000);
      cyc(1, 0, f_fetch(1), "beq_t_fetch");
      cyc(0, 0, f_dec(), "beq_t_decode");
      cyc(0, 1, f_exe(2'b01, 0, 2'b01, 1, 2'b01), "beq_taken_execute");
      cyc(1, 0, f_fetch(1), "beq_n_fetch");
      cyc(0, 0, f_dec(), "beq_n_decode");
      cyc(0, 0, f_exe(2'b01, 0, 2'b01, 1, 2'b00), "beq_not_taken_execute");

      instr(7'b0100011, 3'b011);
      cyc(1, 0, f_fetch(1), "st011_fetch");
      cyc(0, 0, f_dec(), "st011_decode");
      cyc(0, 0, f_trap(1, 0), "st011_illegal_trap");

      instr(7'b0110111, 3'b000);
      for (int i = 0; i < 5; i++) cyc(0, 0, f_fetch(0), "fetch_wait_to_timeout");
      cyc(0, 0, f_trap(0, 1), "fetch_timeout_trap");
      for (int i = 0; i < 4; i++) cyc(0, 0, f_fetch(0), "fetch_wait_to_limit");
      cyc(1, 0, f_fetch(1), "fetch_ready_at_limit");
      cyc(0, 0, f_dec(), "lui_decode");
      cyc(0, 0, f_exe(2'b00, 1, 2'b01, 0, 2'b00), "lui_execute");
      cyc(0, 0, f_wb(2'b00, 1, 2'b01, 2'b00), "lui_wb");

      instr(7'b1101111, 3'b000);
      cyc(1, 0, f_fetch(1), "jal_fetch");
      cyc(0, 0, f_dec(), "jal_decode");
      cyc(0, 0, f_exe(2'b00, 1, 2'b11, 0, 2'b00), "jal_execute");
      cyc(0, 0, f_wb(2'b00, 1, 2'b11, 2'b01), "jal_wb");

      instr(7'b1100111, 3'b000);
      cyc(1, 0, f_fetch(1), "jalr_fetch");
      cyc(0, 0, f_dec(), "jalr_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b11, 0, 2'b00), "jalr_execute");
      cyc(0, 0, f_wb(2'b10, 1, 2'b11, 2'b10), "jalr_wb");

      instr(7'b0010111, 3'b000);
      cyc(1, 0, f_fetch(1), "auipc_fetch");
      cyc(0, 0, f_dec(), "auipc_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b10, 0, 2'b00), "auipc_execute");
      cyc(0, 0, f_wb(2'b10, 1, 2'b10, 2'b00), "auipc_wb");

      instr(7'b0000011, 3'b100);
      cyc(1, 0, f_fetch(1), "lbu_fetch");
      cyc(0, 0, f_dec(), "lbu_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b00, 0, 2'b00), "lbu_execute");
      cyc(1, 0, f_mem(3'b101, 2'b00, 2'b10, 1, 2'b00, 0), "lbu_mem");
      cyc(0, 0, f_wb(2'b10, 1, 2'b00, 2'b00), "lbu_wb");

      instr(7'b0100011, 3'b010);
      cyc(1, 0, f_fetch(1), "sw_fetch");
      cyc(0, 0, f_dec(), "sw_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b01, 0, 2'b00), "sw_execute");
      cyc(1, 0, f_mem(3'b000, 2'b01, 2'b10, 1, 2'b01, 1), "sw_mem_done");

      instr(7'b0100011, 3'b000);
      cyc(1, 0, f_fetch(1), "sb_fetch");
      cyc(0, 0, f_dec(), "sb_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b01, 0, 2'b00), "sb_execute");
      for (int i = 0; i < 5; i++) cyc(0, 0, f_mem(3'b000, 2'b11, 2'b10, 1, 2'b01, 0), "sb_mem_wait");
      cyc(0, 0, f_trap(0, 1), "sb_mem_timeout_trap");

      instr(7'b0000000, 3'b000);
      cyc(1, 0, f_fetch(1), "bad_op_fetch");
      cyc(0, 0, f_dec(), "bad_op_decode");
      cyc(0, 0, f_trap(1, 0), "bad_op_trap");

      instr(7'b0100011, 3'b010);
      cyc(1, 0, f_fetch(1), "swr_fetch");
      cyc(0, 0, f_dec(), "swr_decode");
      cyc(0, 0, f_exe(2'b10, 1, 2'b01, 0, 2'b00), "swr_execute");
      for (int i = 0; i < 2; i++) cyc(0, 0, f_mem(3'b000, 2'b01, 2'b10, 1, 2'b01, 0), "swr_mem_wait");
      rst_n = 1'b0;
      cyc(0, 0, '0, "swr_reset_mid_mem");
      cyc(0, 0, '0, "swr_reset_hold");
      rst_n = 1'b1;
      cyc(0, 0, f_fetch(0), "post_reset_fetch");
      cyc(1, 0, f_fetch(1), "post_reset_fetch_done");
      cyc(0, 0, f_dec(), "post_reset_decode");

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
